// File: rtl/dm_arbiter.sv
// Data-memory port arbiter: core has priority, host gets a forced grant after STARVE_MAX denied cycles.
// Optional core stall counter enabled by defining DM_ARB_STALL_CNT_EN.
module dm_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req,
  input  logic        core_wr,
  input  logic [2:0]  core_ctrl,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [2:0]  host_ctrl,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic [2:0]  mem_ctrl,
  input  logic [31:0] mem_rdata,
  output logic [31:0] stall_count
);

  typedef enum logic {
    S_NORM,
    S_RECOVER
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        host_rvalid_q, host_rvalid_d;
  logic [31:0] host_rdata_q, host_rdata_d;
  logic        gnt;
  logic        stall;

  // Reset gates the grant so nothing reaches the DM while rst_n is low.
  always_comb begin
    gnt = 1'b0;
    if (rst_n && host_req) begin
      gnt = !core_req || (state_q == S_NORM && starve_cnt_q == STARVE_LIM);
    end
    stall = core_req && gnt;
  end

  always_comb begin
    if (gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_ctrl  = host_ctrl;
      mem_wr    = host_wr;
    end else begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_ctrl  = core_ctrl;
      mem_wr    = rst_n && core_req && core_wr;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NORM:    if (stall) state_d = S_RECOVER;
      S_RECOVER: state_d = S_NORM;
      default:   state_d = S_NORM;
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (gnt) begin
      starve_cnt_d = '0;
    end else if (host_req && starve_cnt_q != STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_comb begin
    host_rvalid_d = gnt && !host_wr;
    host_rdata_d  = host_rdata_q;
    if (gnt && !host_wr) begin
      host_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_NORM;
      starve_cnt_q  <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

`ifdef DM_ARB_STALL_CNT_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = '0;
`endif

  assign host_gnt    = gnt;
  assign core_stall  = stall;
  assign core_rdata  = mem_rdata;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: a transaction-level reference model predicts each cycle's
// arbitration result and host read returns; monitors compare against the DUT.
module tb_dm_arbiter;

  localparam int unsigned SM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_wr;
  logic [2:0]  core_ctrl;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall;
  logic        host_req, host_wr;
  logic [2:0]  host_ctrl;
  logic [31:0] host_addr, host_wdata;
  logic        host_gnt, host_rvalid;
  logic [31:0] host_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr;
  logic [2:0]  mem_ctrl;
  logic [31:0] stall_count;

  dm_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_wr(core_wr), .core_ctrl(core_ctrl),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_stall(core_stall),
    .host_req(host_req), .host_wr(host_wr), .host_ctrl(host_ctrl),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Word-addressed data memory standing in for DM.
  logic [31:0] dm [64];
  assign mem_rdata = dm[mem_addr[7:2]];
  always @(posedge clk) if (mem_wr) dm[mem_addr[7:2]] <= mem_wdata;

  typedef struct {
    logic        gnt, stall, wr, rvalid;
    logic [2:0]  ctrl;
    logic [31:0] addr, wdata, cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          errors = 0;
  int          checks = 0;

  // Reference model state: denied cycles of the pending host request, whether the
  // previous cycle stalled the core, a pending read return, stall total, memory image.
  int unsigned model_wait;
  bit          prev_stall;
  bit          rv_pend;
  logic [31:0] model_cnt;
  logic [31:0] ref_mem [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("host_gnt", host_gnt, e.gnt);
      chk("core_stall", core_stall, e.stall);
      chk("mem_wr", mem_wr, e.wr);
      chk("mem_addr", mem_addr, e.addr);
      chk("mem_wdata", mem_wdata, e.wdata);
      chk("mem_ctrl", mem_ctrl, e.ctrl);
      chk("host_rvalid", host_rvalid, e.rvalid);
      chk("stall_count", stall_count, e.cnt);
    end
  end

  always @(negedge clk) begin
    if (rst_n && host_rvalid) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL host_rvalid_unexpected: got 1 expected 0 at %0t", $time);
      end else begin
        chk("host_rdata", host_rdata, rd_q.pop_front());
      end
    end
  end

  task automatic cycle(input bit cr, input bit cw, input logic [2:0] cc, input logic [31:0] ca,
                       input logic [31:0] cd, input bit hr, input bit hw, input logic [2:0] hc,
                       input logic [31:0] ha, input logic [31:0] hd, output bit g);
    exp_t e;
    @(posedge clk); #1;
    core_req = cr; core_wr = cw; core_ctrl = cc; core_addr = ca; core_wdata = cd;
    host_req = hr; host_wr = hw; host_ctrl = hc; host_addr = ha; host_wdata = hd;
    e.gnt    = hr && (!cr || (model_wait >= SM && !prev_stall));
    e.stall  = cr && e.gnt;
    e.addr   = e.gnt ? ha : ca;
    e.wdata  = e.gnt ? hd : cd;
    e.ctrl   = e.gnt ? hc : cc;
    e.wr     = e.gnt ? hw : (cr && cw);
    e.rvalid = rv_pend;
    e.cnt    = model_cnt;
    exp_q.push_back(e);
    if (e.gnt && !hw) rd_q.push_back(ref_mem[ha[7:2]]);
    rv_pend = e.gnt && !hw;
    if (e.wr) ref_mem[e.addr[7:2]] = e.wdata;
    if (e.gnt) model_wait = 0;
    else if (hr && model_wait < SM) model_wait++;
    prev_stall = e.stall;
`ifdef DM_ARB_STALL_CNT_EN
    if (e.stall) model_cnt = model_cnt + 32'd1;
`endif
    g = e.gnt;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete(); rd_q.delete();
    model_wait = 0; prev_stall = 0; rv_pend = 0; model_cnt = '0;
    core_req = 1; core_wr = 1; host_req = 1; host_wr = 1;
    #1;
    chk("rst_host_gnt", host_gnt, 0);
    chk("rst_core_stall", core_stall, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_stall_count", stall_count, 0);
    @(posedge clk); #1;
    core_req = 0; core_wr = 0; host_req = 0; host_wr = 0;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    return {24'h0, r[7:2], 2'b00};
  endfunction

  initial begin
    bit          g;
    int unsigned grants;
    bit          hr, hw;
    logic [2:0]  hc;
    logic [31:0] ha, hd;

    rst_n = 1'b0;
    core_req = 0; core_wr = 0; core_ctrl = '0; core_addr = '0; core_wdata = '0;
    host_req = 0; host_wr = 0; host_ctrl = '0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      dm[i] = '0;
      ref_mem[i] = '0;
    end
    do_reset();

    // Uncontended host write then read back, then a core store.
    cycle(0, 0, 3'd0, 32'h0, 32'h0, 1, 1, 3'b010, 32'h40, 32'hDEADBEEF, g);
    cycle(0, 0, 3'd0, 32'h0, 32'h0, 1, 0, 3'b010, 32'h40, 32'h0, g);
    cycle(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0, g);
    cycle(1, 1, 3'b010, 32'h10, 32'h1234, 0, 0, 3'd0, 32'h0, 32'h0, g);
    cycle(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0, g);

    // Three host reads queued back-to-back under continuous core traffic.
    grants = 0;
    ha = 32'h40;
    for (int c = 0; c < 40 && grants < 3; c++) begin
      cycle(1, $urandom_range(0, 1), 3'b010, rand_addr(), $urandom, 1, 0, 3'b010, ha, 32'h0, g);
      if (g) begin
        grants++;
        ha = rand_addr();
      end
    end
    cycle(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0, g);
    @(negedge clk);
`ifdef DM_ARB_STALL_CNT_EN
    chk("stall_count_after_3", stall_count, 32'd3);
`else
    chk("stall_count_after_3", stall_count, 32'd0);
`endif

    // Reset while a host read return is pending.
    cycle(0, 0, 3'd0, 32'h0, 32'h0, 1, 0, 3'b010, 32'h40, 32'h0, g);
    do_reset();

    // Randomized traffic; host request fields held until granted.
    hr = 0; hw = 0; hc = '0; ha = '0; hd = '0;
    for (int c = 0; c < 2000; c++) begin
      if (!hr && $urandom_range(0, 2) == 0) begin
        hr = 1; hw = $urandom_range(0, 1); hc = 3'($urandom);
        ha = rand_addr(); hd = $urandom;
      end
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1), 3'($urandom), rand_addr(), $urandom,
            hr, hw, hc, ha, hd, g);
      if (g) hr = 0;
    end
    cycle(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0, g);
    cycle(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0, g);
    @(negedge clk); #1;
    chk("read_returns_drained", rd_q.size(), 0);
    chk("expectations_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
